// File: rtl/dot_partial_merge.sv
// ---------------------------------------------------------------------------
// dot_partial_merge
//
// Purpose:
//   Merges the two partial dot-product streams from the dotProduct leaf into
//   one dot product per training sample. Each sample is PARTS beats on each
//   lane. Both lanes are consumed together, one beat from each per cycle.
//   The PARTS-beat sum is built in a wide accumulator, saturated to DATA_BITS
//   and sent on a single AXI-stream toward the sigmoid stage. One ap_start
//   run covers NUM_SAMPLES samples and ends with an ap_done/ap_ready pulse.
//
// Ports:
//   ap_clk, ap_rst_n          clock, synchronous active-low reset
//   ap_start                  level start (may be tied high)
//   ap_done, ap_ready         one-cycle pulse after the last sample of a run
//   ap_idle                   high while waiting for ap_start
//   Input_1_V_*               lane-1 partial sums (TDATA/TVALID/TREADY)
//   Input_2_V_*               lane-2 partial sums (TDATA/TVALID/TREADY)
//   Output_1_V_*              merged, saturated dot product per sample
// ---------------------------------------------------------------------------
module dot_partial_merge #(
  parameter int DATA_BITS   = 32,
  parameter int ACC_BITS    = 40,
  parameter int PARTS       = 4,
  parameter int NUM_SAMPLES = 16
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  input  logic                 ap_start,
  output logic                 ap_done,
  output logic                 ap_idle,
  output logic                 ap_ready,
  input  logic [DATA_BITS-1:0] Input_1_V_TDATA,
  input  logic                 Input_1_V_TVALID,
  output logic                 Input_1_V_TREADY,
  input  logic [DATA_BITS-1:0] Input_2_V_TDATA,
  input  logic                 Input_2_V_TVALID,
  output logic                 Input_2_V_TREADY,
  output logic [DATA_BITS-1:0] Output_1_V_TDATA,
  output logic                 Output_1_V_TVALID,
  input  logic                 Output_1_V_TREADY
);

  localparam int BEAT_W = $clog2(PARTS + 1);
  localparam int SAMP_W = $clog2(NUM_SAMPLES + 1);

  localparam logic [BEAT_W-1:0] LAST_BEAT   = BEAT_W'(PARTS - 1);
  localparam logic [SAMP_W-1:0] LAST_SAMPLE = SAMP_W'(NUM_SAMPLES - 1);

  // Largest and smallest DATA_BITS values, sign-extended to the accumulator
  // width so the clamp compare runs on the full-precision sum.
  localparam logic signed [ACC_BITS-1:0] SAT_MAX =
    {{(ACC_BITS - DATA_BITS + 1){1'b0}}, {(DATA_BITS - 1){1'b1}}};
  localparam logic signed [ACC_BITS-1:0] SAT_MIN =
    {{(ACC_BITS - DATA_BITS + 1){1'b1}}, {(DATA_BITS - 1){1'b0}}};

  localparam logic [DATA_BITS-1:0] OUT_MAX = {1'b0, {(DATA_BITS - 1){1'b1}}};
  localparam logic [DATA_BITS-1:0] OUT_MIN = {1'b1, {(DATA_BITS - 1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_EMIT,
    S_DONE
  } state_e;

  state_e                      state_q;
  logic signed [ACC_BITS-1:0]  acc_q;
  logic [BEAT_W-1:0]           beat_cnt_q;
  logic [SAMP_W-1:0]           sample_cnt_q;
  logic [DATA_BITS-1:0]        out_data_q;
  logic                        out_valid_q;
  logic                        done_q;
  logic                        idle_q;

  logic                        join_d;
  logic signed [ACC_BITS-1:0]  lane1_ext_d;
  logic signed [ACC_BITS-1:0]  lane2_ext_d;
  logic signed [ACC_BITS-1:0]  sum_d;
  logic [DATA_BITS-1:0]        sat_d;

  // A beat only moves when both lanes offer one in the same cycle; a lone
  // valid sees TREADY low so its source keeps holding the word.
  assign join_d = (state_q == S_ACCUM) && Input_1_V_TVALID && Input_2_V_TVALID;

  assign Input_1_V_TREADY = join_d;
  assign Input_2_V_TREADY = join_d;

  // Running sum including the beat pair currently offered, plus its clamped
  // DATA_BITS form used only when this is the sample's last beat.
  always_comb begin
    lane1_ext_d = ACC_BITS'($signed(Input_1_V_TDATA));
    lane2_ext_d = ACC_BITS'($signed(Input_2_V_TDATA));
    sum_d       = acc_q + lane1_ext_d + lane2_ext_d;
    if (sum_d > SAT_MAX) begin
      sat_d = OUT_MAX;
    end else if (sum_d < SAT_MIN) begin
      sat_d = OUT_MIN;
    end else begin
      sat_d = sum_d[DATA_BITS-1:0];
    end
  end

  // Control FSM with all handshake/status outputs kept as registers.
  // Reset (or a new start) discards any partial sum and any word held in EMIT.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q      <= S_IDLE;
      acc_q        <= '0;
      beat_cnt_q   <= '0;
      sample_cnt_q <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      done_q       <= 1'b0;
      idle_q       <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ap_start) begin
            state_q      <= S_ACCUM;
            acc_q        <= '0;
            beat_cnt_q   <= '0;
            sample_cnt_q <= '0;
            idle_q       <= 1'b0;
          end
        end

        S_ACCUM: begin
          if (join_d) begin
            if (beat_cnt_q == LAST_BEAT) begin
              // The accumulator is left as-is here; it is cleared once the
              // word has actually been taken downstream.
              out_data_q  <= sat_d;
              out_valid_q <= 1'b1;
              state_q     <= S_EMIT;
            end else begin
              acc_q      <= sum_d;
              beat_cnt_q <= beat_cnt_q + BEAT_W'(1);
            end
          end
        end

        S_EMIT: begin
          if (Output_1_V_TREADY) begin
            out_valid_q  <= 1'b0;
            acc_q        <= '0;
            beat_cnt_q   <= '0;
            sample_cnt_q <= sample_cnt_q + SAMP_W'(1);
            if (sample_cnt_q == LAST_SAMPLE) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              state_q <= S_ACCUM;
            end
          end
        end

        S_DONE: begin
          // Always pass through one IDLE cycle, even with ap_start held.
          done_q  <= 1'b0;
          idle_q  <= 1'b1;
          state_q <= S_IDLE;
        end

        default: begin
          state_q     <= S_IDLE;
          out_valid_q <= 1'b0;
          done_q      <= 1'b0;
          idle_q      <= 1'b1;
        end
      endcase
    end
  end

  assign Output_1_V_TDATA  = out_data_q;
  assign Output_1_V_TVALID = out_valid_q;
  assign ap_done           = done_q;
  assign ap_ready          = done_q;
  assign ap_idle           = idle_q;

endmodule
